// File: rtl/knn_io_credit_pipe.sv
// -----------------------------------------------------------------------------
// knn_io_credit_pipe
//
// I/O retiming shell for the kNN core.
//   * Host beats (wr_en/rd_en/start/done/k/data) are accepted on
//     s_valid && s_ready. They travel through IN_STAGES free-running timing
//     flops and are then written into a FIFO_DEPTH-entry FIFO facing the core.
//   * One credit is taken per accepted beat and returned per FIFO pop.
//     `level` counts beats in flight plus beats stored. Because s_ready is
//     only high while level < FIFO_DEPTH, a beat that reaches the end of the
//     input pipe always finds a free FIFO slot.
//   * Core results (valid/name/value) are retimed through OUT_STAGES flops
//     toward the host. OUT_STAGES = 0 gives a combinational pass-through.
//
// Ports
//   clk, reset                  single rising-edge clock, synchronous active-high reset
//   s_valid / s_ready           host beat handshake
//   s_wr_en, s_rd_en, s_start,
//   s_done, s_k, s_data         host payload, sampled only on accept
//   m_valid / m_ready           FIFO head toward the core; popped on handshake
//   m_wr_en, m_rd_en, m_start,
//   m_done, m_k, m_data         FIFO head payload
//   core_valid, core_name,
//   core_value                  core result strobe and data
//   out_valid, out_name,
//   out_value                   retimed core result
//   level                       credits in use (in flight + stored)
// -----------------------------------------------------------------------------
module knn_io_credit_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int K_WIDTH    = 32,
    parameter int NAME_WIDTH = 32,
    parameter int IN_STAGES  = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int OUT_STAGES = 1
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          s_wr_en,
    input  logic                          s_rd_en,
    input  logic                          s_start,
    input  logic                          s_done,
    input  logic [K_WIDTH-1:0]            s_k,
    input  logic [DATA_WIDTH-1:0]         s_data,

    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_wr_en,
    output logic                          m_rd_en,
    output logic                          m_start,
    output logic                          m_done,
    output logic [K_WIDTH-1:0]            m_k,
    output logic [DATA_WIDTH-1:0]         m_data,

    input  logic                          core_valid,
    input  logic [NAME_WIDTH-1:0]         core_name,
    input  logic [DATA_WIDTH-1:0]         core_value,
    output logic                          out_valid,
    output logic [NAME_WIDTH-1:0]         out_name,
    output logic [DATA_WIDTH-1:0]         out_value,

    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int PAY_W = 4 + K_WIDTH + DATA_WIDTH;

    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    // ---------------------------------------------------------------- credits
    logic [LVL_W-1:0] r_level;
    logic [LVL_W-1:0] w_level_next;
    logic             w_accept;
    logic             w_pop;

    // Decided from the registered level only, so there is no combinational
    // path from s_valid or m_ready to s_ready.
    assign s_ready  = !reset && (r_level < DEPTH_LVL);
    assign w_accept = s_valid && s_ready;

    // NOTE: every signal assigned in always_comb gets a default first; an
    // incomplete assignment path would infer a latch.
    always_comb begin
        w_level_next = r_level;
        case ({w_accept, w_pop})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
        end else begin
            r_level <= w_level_next;
        end
    end

    assign level = r_level;

    // ------------------------------------------------------------- input pipe
    logic [PAY_W-1:0] w_s_payload;
    logic             r_in_valid   [IN_STAGES];
    logic [PAY_W-1:0] r_in_payload [IN_STAGES];

    assign w_s_payload = {s_wr_en, s_rd_en, s_start, s_done, s_k, s_data};

    // Free-running shift: the credit scheme guarantees the FIFO has space,
    // so the pipe never needs to stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < IN_STAGES; i++) begin
                r_in_valid[i]   <= 1'b0;
                r_in_payload[i] <= '0;
            end
        end else begin
            r_in_valid[0]   <= w_accept;
            r_in_payload[0] <= w_s_payload;
            for (int i = 1; i < IN_STAGES; i++) begin
                r_in_valid[i]   <= r_in_valid[i-1];
                r_in_payload[i] <= r_in_payload[i-1];
            end
        end
    end

    // ------------------------------------------------------------------- FIFO
    logic             w_fifo_wr;
    logic [PAY_W-1:0] w_head;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_fifo_used;
    logic [PAY_W-1:0] r_mem [FIFO_DEPTH];

    assign w_fifo_wr = r_in_valid[IN_STAGES-1];
    assign m_valid   = !reset && (r_fifo_used != '0);
    assign w_pop     = m_valid && m_ready;

    // NOTE: the storage array has no reset; m_valid is derived from the
    // occupancy count, so stale contents are never presented as valid.
    always_ff @(posedge clk) begin
        if (w_fifo_wr && !reset) begin
            r_mem[r_wr_ptr] <= r_in_payload[IN_STAGES-1];
        end
    end

    // Pointers wrap naturally at the power-of-two depth; occupancy is
    // tracked by a counter rather than by comparing pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_used <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_fifo_wr, w_pop})
                2'b10:   r_fifo_used <= r_fifo_used + 1'b1;
                2'b01:   r_fifo_used <= r_fifo_used - 1'b1;
                default: r_fifo_used <= r_fifo_used;
            endcase
        end
    end

    // The head slot is not rewritten while occupied, so the payload stays
    // stable until it is popped.
    assign w_head = r_mem[r_rd_ptr];
    assign {m_wr_en, m_rd_en, m_start, m_done, m_k, m_data} = w_head;

    // ------------------------------------------------------------ result path
    if (OUT_STAGES == 0) begin : g_out_pass
        assign out_valid = core_valid;
        assign out_name  = core_name;
        assign out_value = core_value;
    end else begin : g_out_pipe
        logic                  r_out_valid [OUT_STAGES];
        logic [NAME_WIDTH-1:0] r_out_name  [OUT_STAGES];
        logic [DATA_WIDTH-1:0] r_out_value [OUT_STAGES];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < OUT_STAGES; i++) begin
                    r_out_valid[i] <= 1'b0;
                    r_out_name[i]  <= '0;
                    r_out_value[i] <= '0;
                end
            end else begin
                r_out_valid[0] <= core_valid;
                r_out_name[0]  <= core_name;
                r_out_value[0] <= core_value;
                for (int i = 1; i < OUT_STAGES; i++) begin
                    r_out_valid[i] <= r_out_valid[i-1];
                    r_out_name[i]  <= r_out_name[i-1];
                    r_out_value[i] <= r_out_value[i-1];
                end
            end
        end

        assign out_valid = !reset && r_out_valid[OUT_STAGES-1];
        assign out_name  = r_out_name[OUT_STAGES-1];
        assign out_value = r_out_value[OUT_STAGES-1];
    end

endmodule
